hms_display_scan: RTL and testbench

- Display-side consumer of the 12-hour hh:mm:ss counter outputs (am_pm_bar, hrs, min, sec).
- Converts each field to BCD and time-multiplexes six digits onto a common-anode 7-segment display.
- Takes a per-frame coherent snapshot of the time, and can optionally blink the field currently being edited.
- Sits between the clock core and the board pins.

---
 rtl/hms_pkg.sv | 57 +++++
 rtl/hms_display_scan_if.sv | 25 ++
 rtl/hms_bin2bcd.sv | 39 +++
 rtl/hms_display_scan.sv | 193 +++++++++++++++++++
 tb/tb_hms_display_scan.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/hms_pkg.sv
// Shared constants and types for the hh:mm:ss six-digit display scanner.
// Segment codes are active-low {g,f,e,d,c,b,a}.
package hms_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        FLD_NONE = 2'd0,
        FLD_HRS  = 2'd1,
        FLD_MIN  = 2'd2,
        FLD_SEC  = 2'd3
    } fld_e;

    localparam logic [2:0] DIG_SEC_O = 3'd0;
    localparam logic [2:0] DIG_SEC_T = 3'd1;
    localparam logic [2:0] DIG_MIN_O = 3'd2;
    localparam logic [2:0] DIG_MIN_T = 3'd3;
    localparam logic [2:0] DIG_HRS_O = 3'd4;
    localparam logic [2:0] DIG_HRS_T = 3'd5;

    typedef struct packed {
        logic       am_pm_bar;
        logic [3:0] hrs;
        logic [5:0] min;
        logic [5:0] sec;
    } snap_t;

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_DASH;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/hms_display_scan_if.sv
// Time-field bus from the clock core and the multiplexed display pins.
// master = clock core / board side, slave = display scanner.
interface hms_display_scan_if;

    logic       am_pm_bar;
    logic [3:0] hrs;
    logic [5:0] min;
    logic [5:0] sec;
    logic [1:0] edit_field;
    logic [5:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame_tick;

    modport master (
        output am_pm_bar, hrs, min, sec, edit_field,
        input  an, seg, dp, frame_tick
    );

    modport slave (
        input  am_pm_bar, hrs, min, sec, edit_field,
        output an, seg, dp, frame_tick
    );

endinterface

// File: rtl/hms_bin2bcd.sv
// 6-bit binary (0..63) to two BCD digits by compare/subtract,
// plus a flag for values in 0..59.
module hms_bin2bcd (
    input  logic [5:0] i_bin,
    output logic [2:0] o_tens,
    output logic [3:0] o_ones,
    output logic       o_in_range
);

    logic [5:0] w_r1;
    logic [4:0] w_r2;
    logic [3:0] w_r3;
    logic [2:0] w_t;

    // Each stage bounds the remainder, so it narrows by one bit.
    always_comb begin
        w_t  = 3'd0;
        w_r1 = i_bin;
        if (i_bin >= 6'd40) begin
            w_t  = 3'd4;
            w_r1 = i_bin - 6'd40;
        end
        w_r2 = 5'(w_r1);
        if (w_r1 >= 6'd20) begin
            w_t  = w_t + 3'd2;
            w_r2 = 5'(w_r1 - 6'd20);
        end
        w_r3 = 4'(w_r2);
        if (w_r2 >= 5'd10) begin
            w_t  = w_t + 3'd1;
            w_r3 = 4'(w_r2 - 5'd10);
        end
    end

    assign o_tens     = w_t;
    assign o_ones     = w_r3;
    assign o_in_range = (i_bin <= 6'd59);

endmodule

// File: rtl/hms_display_scan.sv
// Six-digit common-anode scanner for a 12h hh:mm:ss clock, one snapshot per frame.
// Define HMS_BLINK_EN to blink the field selected by edit_field.
module hms_display_scan
    import hms_pkg::*;
#(
    parameter int REFRESH_DIV = 50000,
    parameter int BLINK_DIV   = 12500000
) (
    input  logic               clk,
    input  logic               rst,
    hms_display_scan_if.slave  bus
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    if (REFRESH_DIV < 2 || BLINK_DIV < 2) begin : g_bad_param
        $error("hms_display_scan: dividers must be >= 2");
    end

    logic [PW-1:0] r_presc;
    logic [2:0]    r_index;
    snap_t         r_shadow;
    logic          r_valid;
    logic [5:0]    r_an;
    logic [6:0]    r_seg;
    logic          r_dp;
    logic          r_frame_tick;

    logic          w_tick;
    logic          w_frame;
    logic          w_blink;
    fld_e          w_edit;

    assign w_tick  = (r_presc == PW'(REFRESH_DIV - 1));
    assign w_frame = w_tick && (r_index == DIG_HRS_T);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_presc  <= '0;
            r_index  <= DIG_HRS_T;
            r_shadow <= '0;
            r_valid  <= 1'b0;
        end else begin
            r_presc <= w_tick ? '0 : r_presc + PW'(1);
            if (w_tick) begin
                if (r_index == DIG_HRS_T) begin
                    r_index  <= DIG_SEC_O;
                    r_shadow <= {bus.am_pm_bar, bus.hrs, bus.min, bus.sec};
                    r_valid  <= 1'b1;
                end else begin
                    r_index <= r_index + 3'd1;
                end
            end
        end
    end

`ifdef HMS_BLINK_EN
    localparam int BW = $clog2(BLINK_DIV);

    logic [BW-1:0] r_bcnt;
    logic          r_blink_phase;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bcnt        <= '0;
            r_blink_phase <= 1'b0;
        end else if (r_bcnt == BW'(BLINK_DIV - 1)) begin
            r_bcnt        <= '0;
            r_blink_phase <= ~r_blink_phase;
        end else begin
            r_bcnt <= r_bcnt + BW'(1);
        end
    end

    assign w_blink = r_blink_phase;
    assign w_edit  = fld_e'(bus.edit_field);
`else
    // Without blink support the edit selector is masked to "none".
    assign w_blink = 1'b0;
    assign w_edit  = fld_e'(bus.edit_field & {2{w_blink}});
`endif

    logic [2:0] w_sec_t, w_min_t, w_hrs_t;
    logic [3:0] w_sec_o, w_min_o, w_hrs_o;
    logic       w_sec_ok, w_min_ok, w_hrs_le59;
    logic       w_hrs_ok;

    hms_bin2bcd u_sec (
        .i_bin      (r_shadow.sec),
        .o_tens     (w_sec_t),
        .o_ones     (w_sec_o),
        .o_in_range (w_sec_ok)
    );

    hms_bin2bcd u_min (
        .i_bin      (r_shadow.min),
        .o_tens     (w_min_t),
        .o_ones     (w_min_o),
        .o_in_range (w_min_ok)
    );

    hms_bin2bcd u_hrs (
        .i_bin      ({2'b00, r_shadow.hrs}),
        .o_tens     (w_hrs_t),
        .o_ones     (w_hrs_o),
        .o_in_range (w_hrs_le59)
    );

    assign w_hrs_ok = w_hrs_le59 && (r_shadow.hrs >= 4'd1)
                      && (r_shadow.hrs <= 4'd12);

    fld_e       w_fld;
    logic       w_on;
    logic [6:0] w_dseg;
    logic       w_blank;
    logic [5:0] w_an;
    logic [6:0] w_seg;
    logic       w_dp;

    always_comb begin
        w_fld  = FLD_NONE;
        w_on   = 1'b1;
        w_dseg = SEG_BLANK;
        case (r_index)
            DIG_SEC_O: begin
                w_fld  = FLD_SEC;
                w_dseg = w_sec_ok ? seg_of(w_sec_o) : SEG_DASH;
            end
            DIG_SEC_T: begin
                w_fld  = FLD_SEC;
                w_dseg = w_sec_ok ? seg_of({1'b0, w_sec_t}) : SEG_DASH;
            end
            DIG_MIN_O: begin
                w_fld  = FLD_MIN;
                w_dseg = w_min_ok ? seg_of(w_min_o) : SEG_DASH;
            end
            DIG_MIN_T: begin
                w_fld  = FLD_MIN;
                w_dseg = w_min_ok ? seg_of({1'b0, w_min_t}) : SEG_DASH;
            end
            DIG_HRS_O: begin
                w_fld  = FLD_HRS;
                w_dseg = w_hrs_ok ? seg_of(w_hrs_o) : SEG_DASH;
            end
            DIG_HRS_T: begin
                w_fld = FLD_HRS;
                if (!w_hrs_ok) begin
                    w_dseg = SEG_DASH;
                end else if (r_shadow.hrs < 4'd10) begin
                    w_on = 1'b0;
                end else begin
                    w_dseg = seg_of({1'b0, w_hrs_t});
                end
            end
            default: w_on = 1'b0;
        endcase
    end

    assign w_blank = w_blink && (w_edit != FLD_NONE) && (w_edit == w_fld);

    always_comb begin
        w_an  = 6'h3F;
        w_seg = SEG_BLANK;
        w_dp  = 1'b1;
        if (r_valid) begin
            if (w_on && !w_blank) begin
                w_an  = ~(6'd1 << r_index);
                w_seg = w_dseg;
            end
            w_dp = !((r_index == DIG_SEC_O) && !r_shadow.am_pm_bar);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_an         <= 6'h3F;
            r_seg        <= SEG_BLANK;
            r_dp         <= 1'b1;
            r_frame_tick <= 1'b0;
        end else begin
            r_an         <= w_an;
            r_seg        <= w_seg;
            r_dp         <= w_dp;
            r_frame_tick <= w_frame;
        end
    end

    assign bus.an         = r_an;
    assign bus.seg        = r_seg;
    assign bus.dp         = r_dp;
    assign bus.frame_tick = r_frame_tick;

endmodule

// File: tb/tb_hms_display_scan.sv
// Scoreboard bench for hms_display_scan: random frames checked digit by digit
// against a decimal reference model; also covers reset and HMS_BLINK_EN blinking.
module tb_hms_display_scan;

    localparam int R   = 4;
    localparam int BD  = 48;
    localparam int NFR = 40;

    typedef struct {
        bit am;
        int h;
        int m;
        int s;
    } snap_s;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    hms_display_scan_if bus();

    hms_display_scan #(
        .REFRESH_DIV (R),
        .BLINK_DIV   (BD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int         checks   = 0;
    int         failures = 0;
    int         cyc;
    logic [1:0] ef_seen;
    snap_s      sq[$];
    logic [6:0] segtab[10] = '{7'b1000000, 7'b1111001, 7'b0100100,
                               7'b0110000, 7'b0011001, 7'b0010010,
                               7'b0000010, 7'b1111000, 7'b0000000,
                               7'b0010000};

    always @(posedge clk or negedge rst)
        if (!rst) cyc <= 0;
        else      cyc <= cyc + 1;

    always @(posedge clk) ef_seen <= bus.edit_field;

    // Expected {an, seg, dp} for digit k showing snapshot sn.
    function automatic logic [13:0] ref_dig(int k, snap_s sn, int ef, bit ph);
        int         fld;
        int         v;
        int         d;
        bit         ok;
        bit         on;
        logic [5:0] an;
        logic [6:0] sg;
        logic       dp;
        fld = k / 2;
        v   = (fld == 0) ? sn.s : (fld == 1) ? sn.m : sn.h;
        ok  = (fld == 2) ? (sn.h >= 1 && sn.h <= 12) : (v <= 59);
        on  = 1;
        an  = 6'h3F;
        if (!ok) begin
            sg = 7'b0111111;
        end else begin
            d  = (k % 2 == 1) ? v / 10 : v % 10;
            sg = segtab[d];
            if (k == 5 && sn.h < 10) on = 0;
        end
        if (ph && ef != 0 && ef == 3 - fld) on = 0;
        if (on) an[k] = 1'b0;
        else    sg = 7'h7F;
        dp = (k == 0 && !sn.am) ? 1'b0 : 1'b1;
        return {an, sg, dp};
    endfunction

    function automatic bit cur_phase();
`ifdef HMS_BLINK_EN
        return (cyc >= 1) && (((cyc - 1) / BD) % 2 == 1);
`else
        return 1'b0;
`endif
    endfunction

    task automatic check(string nm, logic [14:0] got, logic [14:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h (an,seg,dp,ft) t=%0t",
                     nm, got, exp, $time);
        end
    endtask

    task automatic set_in(snap_s sn, int ef);
        bus.am_pm_bar  = sn.am;
        bus.hrs        = 4'(sn.h);
        bus.min        = 6'(sn.m);
        bus.sec        = 6'(sn.s);
        bus.edit_field = 2'(ef);
    endtask

    function automatic snap_s rnd_snap();
        snap_s sn;
        sn.am = bit'($urandom_range(0, 1));
        sn.h  = ($urandom_range(0, 9) < 8) ? int'($urandom_range(1, 12))
                                           : int'($urandom_range(0, 15));
        sn.m  = ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, 59))
                                           : int'($urandom_range(0, 63));
        sn.s  = ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, 59))
                                           : int'($urandom_range(0, 63));
        return sn;
    endfunction

    task automatic wait_tick(output bit ok);
        int n;
        n  = 0;
        ok = 0;
        while (n < 200 && !ok) begin
            @(negedge clk);
            n++;
            if (bus.frame_tick === 1'b1) ok = 1;
        end
    endtask

    function automatic logic [14:0] outs();
        return {bus.an, bus.seg, bus.dp, bus.frame_tick};
    endfunction

    snap_s dir[4];

    task automatic stimulus();
        bit    ok;
        snap_s sn;
        snap_s mid;
        int    a;
        int    b;
        for (int f = 1; f < NFR; f++) begin
            wait_tick(ok);
            if (!ok) return;
            if (f < 4) begin
                sn = dir[f];
                a  = 0;
                b  = 9;
            end else begin
                sn  = rnd_snap();
                mid = rnd_snap();
                a   = $urandom_range(1, 8);
                b   = $urandom_range(a + 1, 20);
                repeat (a) @(negedge clk);
                set_in(mid, $urandom_range(0, 3));
            end
            repeat (b - a) @(negedge clk);
            set_in(sn, $urandom_range(0, 3));
            sq.push_back(sn);
        end
    endtask

    task automatic monitor();
        bit    ok;
        int    last;
        snap_s sn;
        for (int f = 0; f < NFR; f++) begin
            wait_tick(ok);
            if (!ok) begin
                check("frame_tick_timeout", 15'h0, 15'h1);
                return;
            end
            if (f > 0)
                check("frame_period", 15'(cyc - last), 15'(R * 6));
            last = cyc;
            if (sq.size() == 0) begin
                check("scoreboard_empty", 15'h0, 15'h1);
                return;
            end
            sn = sq.pop_front();
            for (int k = 0; k < 6; k++) begin
                if (k == 0) @(negedge clk);
                else        repeat (R) @(negedge clk);
                check($sformatf("frame%0d_dig%0d", f, k), outs(),
                      {ref_dig(k, sn, int'(ef_seen), cur_phase()), 1'b0});
            end
        end
    endtask

    initial begin
        snap_s cur;
        dir[0] = '{am: 1'b0, h: 12, m: 34, s: 56};
        dir[1] = '{am: 1'b0, h: 12, m: 34, s: 57};
        dir[2] = '{am: 1'b1, h: 9,  m: 5,  s: 0};
        dir[3] = '{am: 1'b0, h: 0,  m: 60, s: 56};

        rst = 1'b0;
        set_in(dir[0], 2);
        sq.push_back(dir[0]);
        repeat (3) @(negedge clk);
        check("reset_state", outs(), {6'h3F, 7'h7F, 1'b1, 1'b0});
        rst = 1'b1;

        fork
            stimulus();
            monitor();
        join

        cur = rnd_snap();
        set_in(cur, 0);
        repeat ($urandom_range(1, 30)) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("reset_midscan", outs(), {6'h3F, 7'h7F, 1'b1, 1'b0});
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int i = 1; i <= R; i++) begin
            @(negedge clk);
            check($sformatf("post_reset_idle%0d", i), outs(),
                  {6'h3F, 7'h7F, 1'b1, (i == R) ? 1'b1 : 1'b0});
        end
        @(negedge clk);
        check("post_reset_first_digit", outs(),
              {ref_dig(0, cur, int'(ef_seen), cur_phase()), 1'b0});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
